// File: rtl/fetch_pc_gen_if.sv
// Fetch PC generator bus: redirect requests, BTB training and the fetch-address outputs.
// The master side belongs to the rest of the pipeline, and the slave side belongs to
// fetch_pc_gen.
interface fetch_pc_gen_if #(
    parameter int unsigned XLEN = 32
);
    // Redirect and back-pressure requests
    logic            stall;
    logic            trap_valid;
    logic [XLEN-1:0] trap_vector;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_addr;

    // BTB training from execute
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic [XLEN-1:0] upd_target;
    logic            upd_taken;

    // Fetch address and prediction
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    modport master (
        output stall,
        output trap_valid,
        output trap_vector,
        output redirect_valid,
        output redirect_addr,
        output upd_valid,
        output upd_pc,
        output upd_target,
        output upd_taken,
        input  pc,
        input  pred_taken,
        input  pred_target
    );

    modport slave (
        input  stall,
        input  trap_valid,
        input  trap_vector,
        input  redirect_valid,
        input  redirect_addr,
        input  upd_valid,
        input  upd_pc,
        input  upd_target,
        input  upd_taken,
        output pc,
        output pred_taken,
        output pred_target
    );
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch-stage program counter generator. It holds the fetch PC and picks the next one
// from reset, trap, redirect, stall, BTB prediction or pc+4, in that order of priority.
// A direct-mapped BTB with 2-bit saturating counters supplies the predicted targets,
// and the execute stage trains it.
module fetch_pc_gen #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     BTB_ENTRIES  = 16
) (
    input logic           clk,
    input logic           reset,
    fetch_pc_gen_if.slave bus
);
    localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX - 2;

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN - 2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN - 3){1'b0}}, 3'b100};

    // Program counter
    logic [XLEN-1:0] pc_q, pc_d;

    // BTB storage. Only the valid bits are reset, so stale tag/target/ctr values are
    // masked by valid.
    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]        target_q [BTB_ENTRIES];
    logic [1:0]             ctr_q    [BTB_ENTRIES];

    // Lookup side, indexed by the current fetch PC
    logic [IDX-1:0]   rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_hit;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;

    // Training side, indexed by the resolved branch PC
    logic [IDX-1:0]   wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic [XLEN-1:0]  wr_target;
    logic             wr_hit;
    logic             ctr_we;
    logic             tgt_we;
    logic             alloc;
    logic [1:0]       ctr_nxt;

    // The low two bits of upd_pc select no BTB entry and form no part of the tag.
    logic unused_upd_pc_lsb;
    assign unused_upd_pc_lsb = ^bus.upd_pc[1:0];

    assign rd_idx = pc_q[IDX+1:2];
    assign rd_tag = pc_q[XLEN-1:IDX+2];

    assign wr_idx    = bus.upd_pc[IDX+1:2];
    assign wr_tag    = bus.upd_pc[XLEN-1:IDX+2];
    assign wr_target = bus.upd_target & ALIGN_MASK;

    // BTB lookup on the registered PC. It sees the contents from before any update in
    // this cycle.
    always_comb begin
        rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        pred_taken  = rd_hit && ctr_q[rd_idx][1];
        pred_target = pred_taken ? target_q[rd_idx] : '0;
    end

    // Next-PC selection. Trap and redirect win over stall, and reset wins over everything.
    always_comb begin
        pc_d = pc_q + PC_STEP;
        if (reset) begin
            pc_d = RESET_VECTOR & ALIGN_MASK;
        end else if (bus.trap_valid) begin
            pc_d = bus.trap_vector & ALIGN_MASK;
        end else if (bus.redirect_valid) begin
            pc_d = bus.redirect_addr & ALIGN_MASK;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end
    end

    // PC register. reset is already folded into pc_d as the highest-priority source.
    always_ff @(posedge clk) begin
        pc_q <= pc_d;
    end

    // Training decode. A hit moves the counter, and a taken hit also refreshes the
    // target. A taken miss replaces the entry as weakly taken.
    always_comb begin
        wr_hit  = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
        ctr_we  = 1'b0;
        tgt_we  = 1'b0;
        alloc   = 1'b0;
        ctr_nxt = ctr_q[wr_idx];
        if (!reset && bus.upd_valid) begin
            if (wr_hit) begin
                ctr_we = 1'b1;
                if (bus.upd_taken) begin
                    tgt_we  = 1'b1;
                    ctr_nxt = (ctr_q[wr_idx] == 2'd3) ? 2'd3 : ctr_q[wr_idx] + 2'd1;
                end else begin
                    ctr_nxt = (ctr_q[wr_idx] == 2'd0) ? 2'd0 : ctr_q[wr_idx] - 2'd1;
                end
            end else if (bus.upd_taken) begin
                alloc   = 1'b1;
                ctr_we  = 1'b1;
                tgt_we  = 1'b1;
                ctr_nxt = 2'd2;
            end
        end
    end

    // Valid bits. Reset invalidates the whole BTB in one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (alloc) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag, target and counter arrays. These are written only through the decoded enables.
    always_ff @(posedge clk) begin
        if (alloc) begin
            tag_q[wr_idx] <= wr_tag;
        end
        if (tgt_we) begin
            target_q[wr_idx] <= wr_target;
        end
        if (ctr_we) begin
            ctr_q[wr_idx] <= ctr_nxt;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pred_taken  = pred_taken;
    assign bus.pred_target = pred_target;

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Parametrised fetch-stage program counter generator for the RISC-V pipeline, a successor to the simple PC register. It holds the current fetch address and selects the next one from reset, trap, mispredict redirect, stall, branch-prediction target or sequential increment, in fixed priority. An internal direct-mapped branch target buffer (BTB) with 2-bit saturating counters supplies predicted-taken targets. The BTB is trained by the execute stage.

## Interface
- XLEN, 32, address width in bits (≥ 8)
- RESET_VECTOR, 0, PC value loaded on reset; bits [1:0] must be 0
- BTB_ENTRIES, 16, number of BTB entries; power of two, ≥ 2; IDX = log2(BTB_ENTRIES)
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold PC (fetch back-pressure)
- trap_valid  in  1  trap/exception redirect request
- trap_vector  in  XLEN  trap handler address
- redirect_valid  in  1  branch mispredict / jump redirect from execute
- redirect_addr  in  XLEN  correct next fetch address
- upd_valid  in  1  BTB training strobe from execute, one per resolved branch
- upd_pc  in  XLEN  address of the resolved branch
- upd_target  in  XLEN  resolved branch target
- upd_taken  in  1  branch outcome
- pc  out  XLEN  current fetch address (registered)
- pred_taken  out  1  BTB predicts current pc as a taken branch
- pred_target  out  XLEN  predicted target; 0 when pred_taken=0

## Operation
- Address alignment: bits [1:0] of the trap_vector, redirect_addr and upd_target inputs are forced to 0 before use. pc[1:0] is always 0.
- BTB entry fields: valid, tag = addr[XLEN-1:IDX+2], target = XLEN bits, ctr = 2 bits.
- BTB index = addr[IDX+1:2].
- Lookup (combinational on pc): hit = valid && tag match.
  - pred_taken = hit && ctr[1].
  - pred_target = entry target when pred_taken=1, else 0.
- Next-PC priority, highest first:
  1. reset: RESET_VECTOR.
  2. trap_valid: trap_vector.
  3. redirect_valid: redirect_addr.
  4. stall: hold pc.
  5. pred_taken: pred_target.
  6. otherwise: pc + 4.
- trap_valid and redirect_valid override stall.
- pc + 4 wraps modulo 2^XLEN.
- Training (upd_valid=1, and reset=0) at the indexed entry:
  - Entry hit, upd_taken=1: ctr increments, saturating at 3; target is overwritten with upd_target.
  - Entry hit, upd_taken=0: ctr decrements, saturating at 0; target is unchanged.
  - Entry miss, upd_taken=1: allocate the entry with valid=1, the new tag, target=upd_target and ctr=2 (weakly taken). Any previous occupant is replaced.
  - Entry miss, upd_taken=0: no change.
- Reset clears all valid bits in the reset cycle. Target and ctr contents are don't-care after reset.
- Training is ignored during reset.

## Timing
- Reset values after the first clock edge with reset=1: pc=RESET_VECTOR, pred_taken=0, pred_target=0 (all BTB entries invalid).
- pc is registered; the next-PC selection takes effect on the following rising edge.
- pred_taken and pred_target are combinational from pc and BTB state, valid in the same cycle as pc.
- BTB write latency is one cycle. A lookup in the same cycle as an update to the same index sees the pre-update contents. The updated entry is visible from the next cycle.
- If reset is asserted mid-operation, the PC reload and BTB invalidation both take effect on that edge, regardless of stall, trap_valid, redirect_valid or upd_valid.
- The block has no handshake. Every request is consumed in the cycle it is asserted.

## Test plan
All scenarios use XLEN=32, RESET_VECTOR=0x0, BTB_ENTRIES=16 (index = pc[5:2]).
- Sequential and stall: reset for 1 cycle, then 3 idle cycles → pc = 0x0, 0x4, 0x8, 0xC. Then stall=1 for 2 cycles → pc holds 0xC.
- Redirect and priority:
  - stall=1 with redirect_valid=1, redirect_addr=0x103 → next pc=0x100.
  - Same cycle also trap_valid=1, trap_vector=0x200 → next pc=0x200.
- BTB allocate and predict: upd_valid=1, upd_pc=0x10, upd_target=0x80, upd_taken=1. Later, with pc=0x10 → pred_taken=1, pred_target=0x80, next pc=0x80.
- Counter training: from the previous state, one upd_taken=0 update for 0x10 (ctr 2→1) → at pc=0x10, pred_taken=0 and next pc=0x14. Two taken updates → ctr=3, prediction restored.
- Aliasing and same-cycle update:
  - With the 0x10 entry valid, pc=0x50 (same index, different tag) → pred_taken=0.
  - An update to 0x10 in the cycle pc=0x10 → that cycle shows the old prediction.
- Wrap and reset mid-run:
  - redirect_addr=0xFFFFFFFC → following pc=0x0.
  - Reset while the BTB is populated → pc=0x0. At pc=0x10, pred_taken=0.
